val2_shift_sequencer: RTL and testbench

Multi-cycle operand-2 generator for the ARM-style EXE stage: accepts a register value plus the 12-bit shifter operand and produces the full ARM-semantics second ALU operand by iterating a narrow shift engine over several cycles. It replaces a single-step combinational shift with a true variable-amount shift (0–31 bits), and holds the pipeline through a valid/ready handshake and a `busy` stall line to the hazard unit.

---
 rtl/val2_shift_sequencer_pkg.sv | 22 ++
 rtl/val2_shift_sequencer_if.sv | 47 ++++
 rtl/val2_shift_sequencer_shift_step.sv | 47 ++++
 rtl/val2_shift_sequencer.sv | 149 ++++++++++++++
 tb/tb_val2_shift_sequencer.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/val2_shift_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// val2_pkg
// Shared definitions for the operand-2 shift sequencer: word width, shift-type
// codes (instruction bits [6:5]) and the sequencer FSM state encoding.
// Optional feature macro used by the block: VAL2_CARRY_OUT_EN.
// -----------------------------------------------------------------------------
package val2_pkg;

    localparam int WORD_W = 32;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/val2_shift_sequencer_if.sv
// -----------------------------------------------------------------------------
// val2_shift_sequencer_if
// Request/response bundle of the operand-2 sequencer.
//   master : issues requests (in_valid + payload), consumes result (out_ready)
//   slave  : the sequencer itself
// Handshake: a transfer happens on the rising clk edge where valid && ready.
// The request side accepts only while in_ready=1 (sequencer IDLE); the
// response side holds out_valid and result stable until out_ready is seen.
// With VAL2_CARRY_OUT_EN defined the bundle also carries carry_in/carry_out.
// -----------------------------------------------------------------------------
interface val2_shift_sequencer_if;
    import val2_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] rm_val;
    logic              imm;
    logic              ld_or_str;
    logic [11:0]       shift_operand;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] result;
    logic              busy;
`ifdef VAL2_CARRY_OUT_EN
    logic              carry_in;
    logic              carry_out;
`endif

    modport master (
        output in_valid, rm_val, imm, ld_or_str, shift_operand, out_ready,
        input  in_ready, out_valid, result, busy
`ifdef VAL2_CARRY_OUT_EN
        , output carry_in
        , input  carry_out
`endif
    );

    modport slave (
        input  in_valid, rm_val, imm, ld_or_str, shift_operand, out_ready,
        output in_ready, out_valid, result, busy
`ifdef VAL2_CARRY_OUT_EN
        , input  carry_in
        , output carry_out
`endif
    );

endinterface

// File: rtl/val2_shift_sequencer_shift_step.sv
// -----------------------------------------------------------------------------
// val2_shift_step
// Combinational single step of the shift engine: shifts i_operand by i_k
// (1..4) positions using shift type i_op.
// Ports:
//   i_operand   : word being shifted
//   i_op        : SH_LSL / SH_LSR / SH_ASR / SH_ROR
//   i_k         : step size, 1..4
//   o_result    : shifted word
//   o_shift_out : last bit shifted out (only with VAL2_CARRY_OUT_EN)
// -----------------------------------------------------------------------------
module val2_shift_step
    import val2_pkg::*;
(
    input  logic [WORD_W-1:0] i_operand,
    input  logic [1:0]        i_op,
    input  logic [2:0]        i_k,
    output logic [WORD_W-1:0] o_result
`ifdef VAL2_CARRY_OUT_EN
    , output logic            o_shift_out
`endif
);

    always_comb begin
        o_result = i_operand;
        case (i_op)
            SH_LSL:  o_result = i_operand << i_k;
            SH_LSR:  o_result = i_operand >> i_k;
            // Bit 31 is preserved by every ASR step, so the sign captured at
            // accept keeps being replicated across all steps.
            SH_ASR:  o_result = $signed(i_operand) >>> i_k;
            SH_ROR:  o_result = (i_operand >> i_k) | (i_operand << (6'd32 - {3'b000, i_k}));
            default: o_result = i_operand;
        endcase
    end

`ifdef VAL2_CARRY_OUT_EN
    logic [4:0] w_lsl_idx;
    logic [4:0] w_rsh_idx;

    // LSL drops bit 32-k last; right shifts and rotates drop bit k-1 last.
    assign w_lsl_idx = 5'd0 - {2'b00, i_k};
    assign w_rsh_idx = {2'b00, i_k} - 5'd1;
    assign o_shift_out = (i_op == SH_LSL) ? i_operand[w_lsl_idx] : i_operand[w_rsh_idx];
`endif

endmodule

// File: rtl/val2_shift_sequencer.sv
// -----------------------------------------------------------------------------
// val2_shift_sequencer
// Multi-cycle ARM operand-2 generator. Decodes the shifter operand at accept,
// then iterates val2_shift_step BITS_PER_CYCLE (1, 2 or 4) bits per cycle.
// Ports:
//   clk, rst_n  : rising-edge clock, asynchronous active-low reset
//   bus         : val2_shift_sequencer_if.slave (request/response handshake,
//                 result, busy stall line; carry_in/carry_out when enabled)
//   o_dbg_state : current FSM state
// Optional feature macro: VAL2_CARRY_OUT_EN (adds carry_in/carry_out).
// -----------------------------------------------------------------------------
module val2_shift_sequencer
    import val2_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    val2_shift_sequencer_if.slave   bus,
    output state_t                  o_dbg_state
);

    localparam logic [4:0] BPC = 5'(BITS_PER_CYCLE);

    state_t            r_state,     w_state_nxt;
    logic [WORD_W-1:0] r_operand,   w_operand_nxt;
    logic [1:0]        r_op,        w_op_nxt;
    logic [4:0]        r_remaining, w_remaining_nxt;

    logic [WORD_W-1:0] w_dec_operand;
    logic [1:0]        w_dec_op;
    logic [4:0]        w_dec_amt;
    logic [2:0]        w_k;
    logic [WORD_W-1:0] w_step_result;

`ifdef VAL2_CARRY_OUT_EN
    logic r_carry, w_carry_nxt;
    logic w_step_out;
`endif

    // Request decode, in priority order: memory offset, rotated immediate,
    // immediate-shifted register, register-specified shift (unsupported -> 0).
    always_comb begin
        w_dec_operand = '0;
        w_dec_op      = SH_LSL;
        w_dec_amt     = 5'd0;
        if (bus.ld_or_str) begin
            w_dec_operand = {{(WORD_W-12){bus.shift_operand[11]}}, bus.shift_operand};
        end else if (bus.imm) begin
            w_dec_operand = {{(WORD_W-8){1'b0}}, bus.shift_operand[7:0]};
            w_dec_op      = SH_ROR;
            w_dec_amt     = {bus.shift_operand[11:8], 1'b0};
        end else if (!bus.shift_operand[4]) begin
            w_dec_operand = bus.rm_val;
            w_dec_op      = bus.shift_operand[6:5];
            w_dec_amt     = bus.shift_operand[11:7];
        end
    end

    assign w_k = (r_remaining < BPC) ? r_remaining[2:0] : BPC[2:0];

    val2_shift_step u_step (
        .i_operand   (r_operand),
        .i_op        (r_op),
        .i_k         (w_k),
        .o_result    (w_step_result)
`ifdef VAL2_CARRY_OUT_EN
        , .o_shift_out (w_step_out)
`endif
    );

    // FSM next state plus datapath next values.
    always_comb begin
        w_state_nxt     = r_state;
        w_operand_nxt   = r_operand;
        w_op_nxt        = r_op;
        w_remaining_nxt = r_remaining;
`ifdef VAL2_CARRY_OUT_EN
        w_carry_nxt     = r_carry;
`endif
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_operand_nxt   = w_dec_operand;
                    w_op_nxt        = w_dec_op;
                    w_remaining_nxt = w_dec_amt;
`ifdef VAL2_CARRY_OUT_EN
                    w_carry_nxt     = bus.carry_in;
`endif
                    w_state_nxt     = (w_dec_amt == 5'd0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                w_operand_nxt   = w_step_result;
                w_remaining_nxt = r_remaining - {2'b00, w_k};
`ifdef VAL2_CARRY_OUT_EN
                w_carry_nxt     = w_step_out;
`endif
                if (r_remaining == {2'b00, w_k}) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_operand   <= '0;
            r_op        <= SH_LSL;
            r_remaining <= 5'd0;
`ifdef VAL2_CARRY_OUT_EN
            r_carry     <= 1'b0;
`endif
        end else begin
            r_operand   <= w_operand_nxt;
            r_op        <= w_op_nxt;
            r_remaining <= w_remaining_nxt;
`ifdef VAL2_CARRY_OUT_EN
            r_carry     <= w_carry_nxt;
`endif
        end
    end

    // The working register is the result register; it only moves in SHIFT
    // and on accept, so it is stable throughout DONE.
    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.result    = r_operand;
`ifdef VAL2_CARRY_OUT_EN
    assign bus.carry_out = r_carry;
`endif
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_val2_shift_sequencer.sv
// -----------------------------------------------------------------------------
// tb_val2_shift_sequencer
// Two sequencer instances (BITS_PER_CYCLE = 1 and 4) sharing one stimulus
// bus; 'sel' picks which one receives the request and is observed.
// -----------------------------------------------------------------------------
module tb_val2_shift_sequencer;
    import val2_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- shared stimulus ----------------
    logic        sel;
    logic        t_in_valid;
    logic        t_out_ready;
    logic [31:0] t_rm;
    logic        t_imm;
    logic        t_ld;
    logic [11:0] t_so;
    logic        t_carry_in;

    val2_shift_sequencer_if u_if1 ();
    val2_shift_sequencer_if u_if4 ();

    assign u_if1.in_valid      = t_in_valid & ~sel;
    assign u_if4.in_valid      = t_in_valid & sel;
    assign u_if1.rm_val        = t_rm;
    assign u_if4.rm_val        = t_rm;
    assign u_if1.imm           = t_imm;
    assign u_if4.imm           = t_imm;
    assign u_if1.ld_or_str     = t_ld;
    assign u_if4.ld_or_str     = t_ld;
    assign u_if1.shift_operand = t_so;
    assign u_if4.shift_operand = t_so;
    assign u_if1.out_ready     = t_out_ready;
    assign u_if4.out_ready     = t_out_ready;
`ifdef VAL2_CARRY_OUT_EN
    assign u_if1.carry_in      = t_carry_in;
    assign u_if4.carry_in      = t_carry_in;
`endif

    state_t dbg1, dbg4;

    val2_shift_sequencer #(.BITS_PER_CYCLE(1)) u_dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (u_if1),
        .o_dbg_state (dbg1)
    );

    val2_shift_sequencer #(.BITS_PER_CYCLE(4)) u_dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (u_if4),
        .o_dbg_state (dbg4)
    );

    // Observed view of the selected instance.
    logic        m_in_ready, m_out_valid, m_busy;
    logic [31:0] m_result;
    state_t      m_state;
    assign m_in_ready  = sel ? u_if4.in_ready  : u_if1.in_ready;
    assign m_out_valid = sel ? u_if4.out_valid : u_if1.out_valid;
    assign m_busy      = sel ? u_if4.busy      : u_if1.busy;
    assign m_result    = sel ? u_if4.result    : u_if1.result;
    assign m_state     = sel ? dbg4            : dbg1;
`ifdef VAL2_CARRY_OUT_EN
    logic m_carry_out;
    assign m_carry_out = sel ? u_if4.carry_out : u_if1.carry_out;
`endif

    // ---------------- scoreboard ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        sel;
        logic [31:0] rm;
        logic        imm;
        logic        ld;
        logic [11:0] so;
        logic        cin;
        logic [31:0] exp_res;
        int          exp_lat;
        logic        chk_c;
        logic        exp_c;
    } vec_t;

    vec_t vecs[$];

    // ---------------- driver ----------------
    // Issues one request, scrambles the inputs right after the accept edge,
    // measures latency in edges (accept edge = N, first sampled high at N+lat),
    // checks the result, then completes the output handshake.
    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        @(negedge clk);
        sel         = v.sel;
        t_rm        = v.rm;
        t_imm       = v.imm;
        t_ld        = v.ld;
        t_so        = v.so;
        t_carry_in  = v.cin;
        t_out_ready = 1'b0;
        t_in_valid  = 1'b1;
        @(posedge clk);
        #1;
        t_in_valid = 1'b0;
        t_rm       = $urandom();
        t_so       = 12'($urandom());
        t_imm      = ~v.imm;
        t_ld       = ~v.ld;
        t_carry_in = ~v.cin;
        lat = 1;
        while (!m_out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
        check({tag, " result"}, m_result, v.exp_res);
        check({tag, " busy in DONE"}, 32'(m_busy), 32'd1);
        check({tag, " in_ready in DONE"}, 32'(m_in_ready), 32'd0);
`ifdef VAL2_CARRY_OUT_EN
        if (v.chk_c) check({tag, " carry_out"}, 32'(m_carry_out), 32'(v.exp_c));
`endif
        @(negedge clk);
        t_out_ready = 1'b1;
        @(posedge clk);
        #1;
        t_out_ready = 1'b0;
        check({tag, " in_ready after handshake"}, 32'(m_in_ready), 32'd1);
        check({tag, " out_valid after handshake"}, 32'(m_out_valid), 32'd0);
    endtask

    // ---------------- test ----------------
    initial begin
        // sel rm imm ld so cin exp_res exp_lat chk_c exp_c
        vecs.push_back('{1'b0, 32'h0000_0001, 1'b0, 1'b0, 12'h280, 1'b0, 32'h0000_0020,  6, 1'b1, 1'b0}); // LSL #5, k=1
        vecs.push_back('{1'b1, 32'h8000_0000, 1'b0, 1'b0, 12'hFC0, 1'b0, 32'hFFFF_FFFF,  9, 1'b0, 1'b0}); // ASR #31, k=4
        vecs.push_back('{1'b1, 32'h0000_000F, 1'b0, 1'b0, 12'h260, 1'b0, 32'hF000_0000,  2, 1'b0, 1'b0}); // ROR #4, k=4
        vecs.push_back('{1'b0, 32'h0000_000F, 1'b0, 1'b0, 12'h260, 1'b0, 32'hF000_0000,  5, 1'b0, 1'b0}); // ROR #4, k=1
        vecs.push_back('{1'b0, 32'h1234_5678, 1'b1, 1'b0, 12'h4FF, 1'b0, 32'hFF00_0000,  9, 1'b0, 1'b0}); // imm rot 8, k=1
        vecs.push_back('{1'b1, 32'h1234_5678, 1'b1, 1'b0, 12'h4FF, 1'b0, 32'hFF00_0000,  3, 1'b0, 1'b0}); // imm rot 8, k=4
        vecs.push_back('{1'b0, 32'h1234_5678, 1'b1, 1'b1, 12'hFFC, 1'b1, 32'hFFFF_FFFC,  1, 1'b1, 1'b1}); // ld wins over imm
        vecs.push_back('{1'b0, 32'h0000_1234, 1'b0, 1'b0, 12'h010, 1'b0, 32'h0000_0000,  1, 1'b1, 1'b0}); // reg-shift -> 0
        vecs.push_back('{1'b0, 32'h0000_0003, 1'b0, 1'b0, 12'h0A0, 1'b0, 32'h0000_0001,  2, 1'b1, 1'b1}); // LSR #1
        vecs.push_back('{1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 12'h000, 1'b1, 32'hDEAD_BEEF,  1, 1'b1, 1'b1}); // amount 0
        vecs.push_back('{1'b1, 32'h8000_0000, 1'b0, 1'b0, 12'hFA0, 1'b0, 32'h0000_0001,  9, 1'b0, 1'b0}); // LSR #31, k=4
        vecs.push_back('{1'b1, 32'h0000_000F, 1'b0, 1'b0, 12'h180, 1'b0, 32'h0000_0078,  2, 1'b1, 1'b0}); // LSL #3 < k
        vecs.push_back('{1'b1, 32'h1234_5678, 1'b0, 1'b0, 12'h3E0, 1'b0, 32'hF024_68AC,  3, 1'b0, 1'b0}); // ROR #7 = 4+3
        vecs.push_back('{1'b0, 32'h8000_0010, 1'b0, 1'b0, 12'h140, 1'b0, 32'hE000_0004,  3, 1'b1, 1'b0}); // ASR #2

        sel = 1'b0; t_in_valid = 1'b0; t_out_ready = 1'b0; t_rm = '0;
        t_imm = 1'b0; t_ld = 1'b0; t_so = '0; t_carry_in = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check("reset in_ready", 32'(m_in_ready), 32'd1);
            check("reset out_valid", 32'(m_out_valid), 32'd0);
            check("reset result", m_result, 32'h0);
            check("reset busy", 32'(m_busy), 32'd0);
`ifdef VAL2_CARRY_OUT_EN
            check("reset carry_out", 32'(m_carry_out), 32'd0);
`endif
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // ---- backpressure: hold DONE, pulse in_valid, nothing accepted ----
        begin
            int lat;
            @(negedge clk);
            sel = 1'b0; t_rm = 32'h0000_0005; t_imm = 1'b0; t_ld = 1'b0;
            t_so = 12'h080; t_out_ready = 1'b0; t_in_valid = 1'b1;
            @(posedge clk);
            #1;
            t_in_valid = 1'b0;
            lat = 1;
            while (!m_out_valid && lat < 60) begin
                @(posedge clk);
                #1;
                lat++;
            end
            check("bp latency", 32'(lat), 32'd2);
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                t_in_valid = 1'b1;
                t_rm = $urandom();
                t_so = 12'h000;
                @(posedge clk);
                #1;
                check("bp out_valid", 32'(m_out_valid), 32'd1);
                check("bp result", m_result, 32'h0000_000A);
                check("bp busy", 32'(m_busy), 32'd1);
                check("bp state", 32'(m_state), 32'(DONE));
            end
            @(negedge clk);
            t_in_valid = 1'b0;
            t_out_ready = 1'b1;
            @(posedge clk);
            #1;
            t_out_ready = 1'b0;
            check("bp in_ready after handshake", 32'(m_in_ready), 32'd1);
            @(posedge clk);
            #1;
            check("bp no stray accept", 32'(m_out_valid), 32'd0);
            check("bp idle busy", 32'(m_busy), 32'd0);
        end

        // ---- asynchronous reset in the middle of LSL #20 ----
        @(negedge clk);
        sel = 1'b0; t_rm = 32'h0000_0001; t_imm = 1'b0; t_ld = 1'b0;
        t_so = 12'hA00; t_out_ready = 1'b0; t_in_valid = 1'b1;
        @(posedge clk);
        #1;
        t_in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midop state", 32'(m_state), 32'(SHIFT));
        check("midop busy", 32'(m_busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst in_ready", 32'(m_in_ready), 32'd1);
        check("async rst out_valid", 32'(m_out_valid), 32'd0);
        check("async rst result", m_result, 32'h0);
        check("async rst busy", 32'(m_busy), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec('{1'b0, 32'h0000_0001, 1'b0, 1'b0, 12'hA00, 1'b0, 32'h0010_0000, 21, 1'b1, 1'b0}, "post-reset LSL20");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
